// File: rtl/rw_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rw_pkg
// Description : Shared types for the multi-channel memory read/write arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package rw_pkg;

    // Command codes presented to the SRAM-style memory port
    typedef enum logic [1:0] {
        INSTR_IDLE  = 2'b00,
        INSTR_READ  = 2'b01,
        INSTR_WRITE = 2'b10
    } instr_t;

    // Controller states
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        WAIT  = 2'b10,
        DONE  = 2'b11
    } rw_state_t;

    // Width of a channel index; a single channel still needs one bit
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin arbiter. Scans the request vector
//               starting at the pointer and grants the first active channel.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import rw_pkg::*;
#(
    parameter  int N_CH  = 2,
    localparam int IDX_W = idx_width(N_CH)
) (
    input  logic [N_CH-1:0]  i_req,
    input  logic [IDX_W-1:0] i_ptr,
    input  logic             i_en,
    output logic [N_CH-1:0]  o_grant,
    output logic [IDX_W-1:0] o_grant_idx
);

    // Walk the channels in rotation from the pointer; first hit wins
    always_comb begin
        int   v_idx;
        logic v_found;
        o_grant     = '0;
        o_grant_idx = '0;
        v_found     = 1'b0;
        v_idx       = 0;
        for (int k = 0; k < N_CH; k++) begin
            v_idx = (int'(i_ptr) + k) % N_CH;
            if (i_en && !v_found && i_req[v_idx]) begin
                v_found          = 1'b1;
                o_grant[v_idx]   = 1'b1;
                o_grant_idx      = IDX_W'(v_idx);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_rw_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_rw_arbiter
// Description : Round-robin arbitration of N_CH requesters onto one
//               SRAM-style port, with busy handshaking, per-channel done
//               pulses and a busy-timeout abort flagged through rsp_err.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_rw_arbiter
    import rw_pkg::*;
#(
    parameter int N_CH    = 2,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_CH-1:0]          req_valid,
    input  logic [N_CH-1:0]          req_write,
    input  logic [N_CH*ADDR_W-1:0]   req_addr,
    input  logic [N_CH*DATA_W-1:0]   req_wdata,
    output logic [N_CH-1:0]          req_ready,
    output logic [N_CH-1:0]          rsp_done,
    output logic [DATA_W-1:0]        rsp_rdata,
    output logic                     rsp_err,
    output logic [1:0]               mem_instruction,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    input  logic                     mem_busy,
    input  logic [DATA_W-1:0]        mem_rdata
);

    localparam int IDX_W = idx_width(N_CH);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [IDX_W-1:0] c_last_ch   = IDX_W'(N_CH - 1);
    localparam logic [CNT_W-1:0] c_cnt_max   = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] c_cnt_abort = CNT_W'(TIMEOUT - 1);

    rw_state_t          r_state;
    rw_state_t          w_state_nxt;
    logic [IDX_W-1:0]   r_ptr;
    logic [IDX_W-1:0]   r_ch;
    instr_t             r_op;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_wdata;
    logic [DATA_W-1:0]  r_rdata;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_err;

    logic [N_CH-1:0]    w_grant;
    logic [IDX_W-1:0]   w_grant_idx;
    logic               w_grant_any;
    logic [IDX_W-1:0]   w_ptr_nxt;
    logic               w_timeout_hit;

    rr_arbiter #(
        .N_CH (N_CH)
    ) u_rr_arbiter (
        .i_req       (req_valid),
        .i_ptr       (r_ptr),
        .i_en        (r_state == IDLE),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx)
    );

    assign w_grant_any   = |w_grant;
    assign w_ptr_nxt     = (w_grant_idx == c_last_ch) ? '0 : w_grant_idx + IDX_W'(1);
    // This busy cycle is the TIMEOUT-th one spent waiting
    assign w_timeout_hit = (r_cnt == c_cnt_abort);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; an abort with busy still high takes the DONE path
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_grant_any) w_state_nxt = ISSUE;
            ISSUE:   if (!mem_busy) w_state_nxt = WAIT;
            WAIT:    if (!mem_busy || w_timeout_hit) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Request latches, pointer, timeout counter and captured read data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr   <= '0;
            r_ch    <= '0;
            r_op    <= INSTR_IDLE;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant_any) begin
                        r_ch    <= w_grant_idx;
                        r_op    <= req_write[w_grant_idx] ? INSTR_WRITE : INSTR_READ;
                        r_addr  <= req_addr[int'(w_grant_idx)*ADDR_W +: ADDR_W];
                        r_wdata <= req_wdata[int'(w_grant_idx)*DATA_W +: DATA_W];
                        r_ptr   <= w_ptr_nxt;
                    end
                end
                WAIT: begin
                    if (!mem_busy) begin
                        r_rdata <= (r_op == INSTR_READ) ? mem_rdata : '0;
                    end else begin
                        if (r_cnt != c_cnt_max) begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                        if (w_timeout_hit) begin
                            r_err <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    r_cnt   <= '0;
                    r_err   <= 1'b0;
                    r_rdata <= '0;
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    // Handshake and response outputs decoded from the current state
    always_comb begin
        req_ready       = w_grant;
        rsp_done        = '0;
        rsp_rdata       = '0;
        rsp_err         = 1'b0;
        mem_instruction = INSTR_IDLE;
        if (r_state == ISSUE) begin
            mem_instruction = r_op;
        end
        if (r_state == DONE) begin
            rsp_done[r_ch] = 1'b1;
            rsp_rdata      = r_rdata;
            rsp_err        = r_err;
        end
    end

    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_rw_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_rw_arbiter
// Description : Self-checking bench for mem_rw_arbiter: directed scenarios
//               followed by randomized transactions against a
//               transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_rw_arbiter;

    localparam int N_CH    = 2;
    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 8;
    localparam int TIMEOUT = 4;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [N_CH-1:0]        req_valid;
    logic [N_CH-1:0]        req_write;
    logic [N_CH*ADDR_W-1:0] req_addr;
    logic [N_CH*DATA_W-1:0] req_wdata;
    logic [N_CH-1:0]        req_ready;
    logic [N_CH-1:0]        rsp_done;
    logic [DATA_W-1:0]      rsp_rdata;
    logic                   rsp_err;
    logic [1:0]             mem_instruction;
    logic [ADDR_W-1:0]      mem_addr;
    logic [DATA_W-1:0]      mem_wdata;
    logic                   mem_busy;
    logic [DATA_W-1:0]      mem_rdata;

    always #5 clk = ~clk;

    mem_rw_arbiter #(
        .N_CH    (N_CH),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_write       (req_write),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .req_ready       (req_ready),
        .rsp_done        (rsp_done),
        .rsp_rdata       (rsp_rdata),
        .rsp_err         (rsp_err),
        .mem_instruction (mem_instruction),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_busy        (mem_busy),
        .mem_rdata       (mem_rdata)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Requester model: what each channel currently wants
    logic       pv [N_CH];
    logic       pw [N_CH];
    logic [7:0] pa [N_CH];
    logic [7:0] pd [N_CH];
    int         ptr_m;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_reqs();
        for (int c = 0; c < N_CH; c++) begin
            req_valid[c]               = pv[c];
            req_write[c]               = pw[c];
            req_addr[c*ADDR_W +: ADDR_W]  = pa[c];
            req_wdata[c*DATA_W +: DATA_W] = pd[c];
        end
    endtask

    task automatic set_req(input int c, input logic wr, input logic [7:0] a, input logic [7:0] d);
        pv[c] = 1'b1;
        pw[c] = wr;
        pa[c] = a;
        pd[c] = d;
    endtask

    task automatic new_req(input int c);
        set_req(c, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
    endtask

    // Round-robin rule: first pending channel at or after the pointer
    function automatic int model_grant();
        for (int k = 0; k < N_CH; k++) begin
            if (pv[(ptr_m + k) % N_CH]) return (ptr_m + k) % N_CH;
        end
        return -1;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, req_ready, 0);
        check({tag, "_done"},  rsp_done, 0);
        check({tag, "_rdata"}, rsp_rdata, 0);
        check({tag, "_err"},   rsp_err, 0);
        check({tag, "_instr"}, mem_instruction, 0);
        check({tag, "_addr"},  mem_addr, 0);
        check({tag, "_wdata"}, mem_wdata, 0);
    endtask

    // One complete transaction starting in IDLE.
    // stall: busy cycles in ISSUE; wb: busy cycles in WAIT (>= TIMEOUT aborts)
    // mode: 0 no new requests, 1 re-request granted channel, 2 random traffic
    task automatic run_op(input int stall, input int wb, input logic [7:0] rd, input int mode);
        int         g;
        int         nb;
        logic       is_wr;
        logic [7:0] a;
        logic [7:0] d;
        logic       err_e;
        logic [7:0] rd_e;
        if (mode == 2) begin
            for (int c = 0; c < N_CH; c++) begin
                if (pv[c] && $urandom_range(0, 5) == 0) pv[c] = 1'b0;
            end
        end
        if (model_grant() < 0) new_req(int'($urandom_range(0, N_CH - 1)));
        drive_reqs();
        mem_busy = 1'b0;
        g     = model_grant();
        is_wr = pw[g];
        a     = pa[g];
        d     = pd[g];
        @(negedge clk);
        check("grant", req_ready, 32'(1) << g);
        check("idle_instr", mem_instruction, 0);
        check("idle_done", rsp_done, 0);
        tick();
        pv[g] = 1'b0;
        ptr_m = (g + 1) % N_CH;
        if (mode == 1) begin
            new_req(g);
        end else if (mode == 2) begin
            for (int c = 0; c < N_CH; c++) begin
                if (!pv[c] && $urandom_range(0, 1) == 1) new_req(c);
            end
        end
        drive_reqs();
        for (int i = 0; i <= stall; i++) begin
            mem_busy = (i < stall);
            @(negedge clk);
            check("issue_instr", mem_instruction, is_wr ? 32'd2 : 32'd1);
            check("issue_addr", mem_addr, a);
            check("issue_wdata", mem_wdata, d);
            check("issue_ready", req_ready, 0);
            tick();
        end
        nb = (wb >= TIMEOUT) ? TIMEOUT : wb;
        for (int i = 0; i < nb; i++) begin
            mem_busy  = 1'b1;
            mem_rdata = 8'($urandom);
            @(negedge clk);
            check("wait_instr", mem_instruction, 0);
            check("wait_done", rsp_done, 0);
            tick();
        end
        if (wb < TIMEOUT) begin
            mem_busy  = 1'b0;
            mem_rdata = rd;
            @(negedge clk);
            check("wait_instr", mem_instruction, 0);
            check("wait_done", rsp_done, 0);
            tick();
        end
        mem_busy  = 1'($urandom_range(0, 1));
        mem_rdata = 8'($urandom);
        err_e = (wb >= TIMEOUT);
        rd_e  = (!is_wr && !err_e) ? rd : 8'd0;
        @(negedge clk);
        check("done_onehot", rsp_done, 32'(1) << g);
        check("done_rdata", rsp_rdata, rd_e);
        check("done_err", rsp_err, err_e);
        check("done_addr", mem_addr, a);
        check("done_ready", req_ready, 0);
        tick();
        mem_busy = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int c = 0; c < N_CH; c++) begin
            pv[c] = 1'b0; pw[c] = 1'b0; pa[c] = 8'd0; pd[c] = 8'd0;
        end
        ptr_m     = 0;
        rst       = 1'b1;
        mem_busy  = 1'b0;
        mem_rdata = '0;
        drive_reqs();
        tick();
        tick();
        @(negedge clk);
        check_all_zero("reset");
        tick();
        rst = 1'b0;

        // ch0 read addr 50, memory returns 200
        set_req(0, 1'b0, 8'd50, 8'd0);
        run_op(0, 0, 8'd200, 0);

        // ch1 write addr 100 data 255
        set_req(1, 1'b1, 8'd100, 8'd255);
        run_op(0, 0, 8'h5A, 0);

        // both channels continuously requesting: grants alternate
        new_req(0);
        new_req(1);
        for (int k = 0; k < 4; k++) run_op(0, 0, 8'($urandom), 1);

        // busy held in ISSUE for 3 cycles
        run_op(3, 0, 8'($urandom), 1);

        // busy stuck in WAIT: abort, then the next request proceeds
        run_op(0, TIMEOUT, 8'($urandom), 1);
        run_op(0, TIMEOUT - 1, 8'($urandom), 1);
        run_op(0, 0, 8'($urandom), 1);

        // randomized traffic
        for (int k = 0; k < 60; k++) begin
            run_op(int'($urandom_range(0, 2)), int'($urandom_range(0, TIMEOUT + 1)),
                   8'($urandom), 2);
        end

        // reset in the middle of WAIT drops the operation
        for (int c = 0; c < N_CH; c++) pv[c] = 1'b0;
        set_req(0, 1'b0, 8'd77, 8'd0);
        drive_reqs();
        tick();
        pv[0] = 1'b0;
        drive_reqs();
        tick();
        mem_busy = 1'b1;
        tick();
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("midwait_rst");
        tick();
        rst      = 1'b0;
        mem_busy = 1'b0;
        ptr_m    = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_done", rsp_done, 0);
            check("post_rst_instr", mem_instruction, 0);
            tick();
        end
        // pointer back at 0: with both requesting, channel 0 wins
        new_req(0);
        new_req(1);
        run_op(0, 0, 8'($urandom), 0);
        run_op(1, 2, 8'($urandom), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
